led_green_driver: RTL

//  Downstream stage of the green-LED PIO. Takes its 9-bit out_port as led_in
//  and drives the physical LEDG pins.

---
 rtl/led_drv_pkg.sv | 19 +
 rtl/led_green_driver_if.sv | 21 ++
 rtl/led_pulse_stretch.sv | 45 ++++
 rtl/led_green_driver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/led_drv_pkg.sv
// Shared constants for the green-LED driver: register map, CTRL bit positions
// and register reset values.
package led_drv_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_CTRL   = 2'd0;
  localparam reg_addr_t ADDR_BRIGHT = 2'd1;
  localparam reg_addr_t ADDR_BLINK  = 2'd2;
  localparam reg_addr_t ADDR_STATUS = 2'd3;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_BLINK_EN   = 1;
  localparam int CTRL_STRETCH_EN = 2;

  localparam logic [2:0]  CTRL_RST  = 3'b001;
  localparam logic [15:0] BLINK_RST = 16'd250;

endpackage

// File: rtl/led_green_driver_if.sv
// Avalon-MM style configuration bus shared by the PIO master and the LED driver.
interface led_green_driver_if;
  import led_drv_pkg::*;

  reg_addr_t   address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/led_pulse_stretch.sv
// One LED lane: holds the lane on for STRETCH_TICKS ticks after its request
// drops, so single-cycle software pulses remain visible.
module led_pulse_stretch #(
  parameter int STRETCH_TICKS = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic led_q,
  input  logic tick,
  input  logic stretch_en,
  output logic stretched
);

  localparam int CNT_W = (STRETCH_TICKS < 1) ? 1 : $clog2(STRETCH_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_TICKS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  // A high request (new or retriggered) always reloads; decay runs on ticks only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (!stretch_en) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (led_q) begin
      state <= ST_HOLD;
      cnt   <= CNT_LOAD;
    end else if (state == ST_HOLD) begin
      if (cnt == '0) begin
        state <= ST_IDLE;
      end else if (tick) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign stretched = led_q | (stretch_en & (state == ST_HOLD));

endmodule

// File: rtl/led_green_driver.sv
// Green-LED output stage: registers the PIO request, then applies pulse
// stretching, global PWM brightness and optional blinking before the pins.
module led_green_driver #(
  parameter int N_LEDS        = 9,
  parameter int PWM_BITS      = 8,
  parameter int TICK_DIV      = 50000,
  parameter int STRETCH_TICKS = 50
) (
  input  logic              clk,
  input  logic              reset,
  led_green_driver_if.slave bus,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] led_out
);
  import led_drv_pkg::*;

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic                wr;
  logic [2:0]          ctrl_q;
  logic [PWM_BITS-1:0] bright_q;
  logic [15:0]         blink_q;
  logic [N_LEDS-1:0]   led_q;
  logic [N_LEDS-1:0]   stretched;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [15:0]         blk_cnt;
  logic                phase;
  logic                enable;
  logic                blink_en;
  logic                stretch_en;
  logic                unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign enable       = ctrl_q[CTRL_ENABLE];
  assign blink_en     = ctrl_q[CTRL_BLINK_EN];
  assign stretch_en   = ctrl_q[CTRL_STRETCH_EN];
  assign unused_wdata = ^bus.writedata[31:16];

  // Register file; STATUS is read-only so writes to it fall through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_RST;
      bright_q <= '1;
      blink_q  <= BLINK_RST;
    end else if (wr) begin
      case (bus.address)
        ADDR_CTRL:   ctrl_q   <= bus.writedata[2:0];
        ADDR_BRIGHT: bright_q <= bus.writedata[PWM_BITS-1:0];
        ADDR_BLINK:  blink_q  <= bus.writedata[15:0];
        default:     ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL:   bus.readdata = 32'(ctrl_q);
      ADDR_BRIGHT: bus.readdata = 32'(bright_q);
      ADDR_BLINK:  bus.readdata = 32'(blink_q);
      ADDR_STATUS: bus.readdata = 32'(led_out);
      default:     bus.readdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      led_q   <= led_in;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign tick   = (pre_cnt == PRE_MAX);
  assign pwm_on = (&bright_q) | (pwm_cnt < bright_q);

  // A BLINK write restarts the blink cycle and beats a same-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (wr && bus.address == ADDR_BLINK) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (!blink_en || blink_q == '0) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (tick) begin
      if (blk_cnt == blink_q - 16'd1) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    led_pulse_stretch #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_stretch (
      .clk       (clk),
      .reset     (reset),
      .led_q     (led_q[i]),
      .tick      (tick),
      .stretch_en(stretch_en),
      .stretched (stretched[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      led_out <= {N_LEDS{enable & phase & pwm_on}} & stretched;
    end
  end

endmodule
